num_rom_arbiter: RTL
====================

NUM_ROM_ARBITER -- requirements
Module: num_rom_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, ROM address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, ROM data width.
REQ-004 SHALL have parameter RD_LATENCY, default 1, ROM read latency in cycles (1..3): 1 without output register, 2 with.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port en, input, 1, global enable; low blocks new grants.
REQ-008 SHALL have port req, input, N_REQ, per-requester read request, level.
REQ-009 SHALL have port req_addr, input, N_REQ*ADDR_WIDTH, packed addresses; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port gnt, output, N_REQ, one-hot grant; address accepted this cycle.
REQ-011 SHALL have port rsp_valid, output, N_REQ, one-hot response strobe.
REQ-012 SHALL have port rsp_data, output, DATA_WIDTH, read data, shared by all requesters.
REQ-013 SHALL have port rom_addr, output, ADDR_WIDTH, address to ROM.
REQ-014 SHALL have port rom_clk_en, output, 1, ROM clock enable.
REQ-015 SHALL have port rom_rd_data, input, DATA_WIDTH, ROM read data.

Function
REQ-016 SHALL issue at most one read per cycle; gnt is combinational from req, en and the priority pointer, asserted in the cycle rom_addr carries the granted address.
REQ-017 SHALL grant, when en=1 and req!=0, the first set req bit at or after the pointer, scanning upward modulo N_REQ.
REQ-018 SHALL move the pointer to (granted index + 1) mod N_REQ on the clock edge ending a grant cycle; no grant leaves it unchanged.
REQ-019 SHALL let a requester see gnt[i] and then drop req[i] or present a new address in the next cycle; a held req[i] is a new request each cycle.
REQ-020 SHALL drive rom_addr to the granted slice, and hold its last value when there is no grant.
REQ-021 SHALL pass an N_REQ-bit one-hot tag through a RD_LATENCY-deep shift register; rsp_valid[i]=1 exactly RD_LATENCY cycles after the gnt[i] cycle.
REQ-022 SHALL drive rsp_data = rom_rd_data combinationally, valid only while some rsp_valid bit is 1.
REQ-023 SHALL hold rom_clk_en=1 when a grant is issued or any tag is in flight, and 0 otherwise.
REQ-024 SHALL keep in-flight reads running to completion when en falls; only new grants stop.
REQ-025 SHALL sustain full throughput: with a single requester holding req, that requester is granted every cycle.
REQ-026 SHALL keep the pointer stable when req=0 or en=0, even if a response is arriving.

Reset
REQ-027 SHALL, on rst assertion, immediately clear the pointer to 0, clear all tag stages, and drive gnt=0, rsp_valid=0, rom_clk_en=0, rom_addr=0.
REQ-028 SHALL discard reads in flight at reset; no rsp_valid for them after rst deasserts.
REQ-029 SHALL allow a grant in the first cycle after rst deasserts, with requester 0 at highest priority.

Structure
REQ-030 SHALL place the RD_LATENCY bounds and the N_REQ maximum as constants in a shared package num_rom_pkg.
REQ-031 SHALL put the round-robin pick and the pointer in one sub-module, num_rom_rr_arb (inputs req, en; outputs one-hot gnt, granted index).
REQ-032 SHALL leave the ROM primitive outside the block; the top level connects rom_* ports to the ROM instance.

Verification
REQ-033 SHALL cover: N_REQ=4, RD_LATENCY=1, req=4'b1111 held 8 cycles -> gnt order 0,1,2,3,0,1,2,3; each rsp_valid one cycle after its gnt with correct ROM word.
REQ-034 SHALL cover: RD_LATENCY=2, only req[2] held, addr 5,6,7 -> gnt[2] three consecutive cycles; rsp_data = ROM[5],ROM[6],ROM[7] on cycles +2,+3,+4.
REQ-035 SHALL cover: pointer=3 with req=4'b0101 -> gnt[0] first, then gnt[2]; pointer becomes 1, then 3.
REQ-036 SHALL cover: en dropped the cycle after gnt[1] with RD_LATENCY=2 -> no new gnt; rsp_valid[1] still fires 2 cycles after gnt; rom_clk_en falls afterwards.
REQ-037 SHALL cover: rst pulsed mid-stream with 2 reads in flight -> all outputs 0 at once; no stale rsp_valid; first post-reset grant goes to requester 0.
REQ-038 SHALL cover: req=0 for 5 cycles -> gnt=0, rom_clk_en=0, pointer unchanged.

Source files
------------

// File: rtl/num_rom_pkg.sv
// Shared constants and helpers for the round-robin ROM read arbiter.
package num_rom_pkg;

    localparam int unsigned RdLatencyMin = 1;
    localparam int unsigned RdLatencyMax = 3;
    localparam int unsigned NReqMin      = 2;
    localparam int unsigned NReqMax      = 8;

    // Requester index width; a single bit is kept even for two requesters.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/num_rom_rr_arb.sv
// Round-robin pick with rotating priority pointer; grant is combinational.
module num_rom_rr_arb
    import num_rom_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    int               cand;

    // Scan upward from the pointer, wrapping at N_REQ; first set request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= int'(N_REQ)) begin
                cand = cand - int'(N_REQ);
            end
            if (!gnt_any && en && !rst && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = IDX_W'(cand);
                gnt_any   = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/num_rom_arbiter.sv
// Shares one external ROM between N_REQ requesters; a one-hot tag pipeline
// matching the ROM read latency steers the returning word to its requester.
module num_rom_arbiter
    import num_rom_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic [ADDR_WIDTH-1:0]       rom_addr,
    output logic                        rom_clk_en,
    input  logic [DATA_WIDTH-1:0]       rom_rd_data
);

    localparam int unsigned IdxW = idx_width(N_REQ);
    localparam int unsigned Lat  = (RD_LATENCY < RdLatencyMin) ? RdLatencyMin :
                                   (RD_LATENCY > RdLatencyMax) ? RdLatencyMax : RD_LATENCY;

    logic [IdxW-1:0]       gnt_idx;
    logic                  gnt_any;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic [N_REQ-1:0]      tag_q [Lat];
    logic                  in_flight;

    num_rom_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IdxW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Address is presented in the grant cycle itself; otherwise the last one is held.
    always_comb begin
        rom_addr = rom_addr_q;
        if (gnt_any) begin
            rom_addr = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(Lat); s++) begin
                tag_q[s] <= '0;
            end
            rom_addr_q <= '0;
        end else begin
            tag_q[0] <= gnt;
            for (int s = 1; s < int'(Lat); s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            rom_addr_q <= rom_addr;
        end
    end

    always_comb begin
        in_flight = 1'b0;
        for (int s = 0; s < int'(Lat); s++) begin
            in_flight = in_flight | (|tag_q[s]);
        end
    end

    assign rsp_valid  = tag_q[Lat-1];
    assign rsp_data   = rom_rd_data;
    assign rom_clk_en = gnt_any | in_flight;

endmodule
